ex_mem_reg: RTL
===============

Name: ex_mem_reg

Overview:
- Pipeline register between the EX stage (ALU result and zero flag) and the MEM stage of the 5-stage RV32 core.
- Captures the ALU result, zero flag, store data, destination register and MEM/WB control bits.
- Resolves BEQ-type branches from the registered zero flag and issues a single-cycle redirect to fetch.
- Supports stall (hold), flush (bubble insertion) and valid tracking.

Parameters:
- XLEN, 32, datapath width.
- REG_ADDR_W, 5, register index width.

Ports:
- clk  input  1  core clock, rising-edge.
- rst_n  input  1  reset, asynchronous, active-low.
- stall_i  input  1  hold all registers this cycle.
- flush_i  input  1  replace the captured entry with a bubble.
- ex_valid_i  input  1  EX stage holds a real instruction.
- ex_alu_out_i  input  XLEN  ALU result.
- ex_zero_i  input  1  ALU zero flag.
- ex_rs2_data_i  input  XLEN  forwarded rs2 value (store data).
- ex_rd_i  input  REG_ADDR_W  destination register.
- ex_br_target_i  input  XLEN  precomputed branch target (PC + imm).
- ex_reg_write_i, ex_mem_read_i, ex_mem_write_i, ex_mem_to_reg_i, ex_branch_i  input  1 each  control bits.
- mem_valid_o  output  1  entry valid.
- mem_alu_out_o  output  XLEN  registered ALU result (memory address or writeback value).
- mem_wdata_o  output  XLEN  registered store data.
- mem_rd_o  output  REG_ADDR_W  registered destination register.
- mem_reg_write_o, mem_mem_read_o, mem_mem_write_o, mem_mem_to_reg_o  output  1 each  registered control bits.
- pc_src_o  output  1  branch-taken redirect pulse.
- br_target_o  output  XLEN  registered branch target.

Behaviour:
- Reset (rst_n=0, asynchronous): all outputs 0, internal br_fired=0. Reset mid-stall or mid-branch discards the entry; no pc_src_o pulse after release.
- Per rising edge, update priority is flush > stall > load.
- Flush: valid=0, all control bits=0, data/rd/target=0, br_fired=0. Flush with stall asserted together: flush wins.
- Stall: every register holds its value, including br_fired.
- Load: all fields captured from ex_*; mem_valid_o=ex_valid_i; br_fired=0.
- Bubble load: when ex_valid_i=0, all captured control bits are forced to 0. Data fields are still captured and are don't-care.
- x0 guard: when ex_rd_i=0, captured reg_write is forced to 0.
- Store data: mem_wdata_o is the captured ex_rs2_data_i, passed unmodified.
- Branch resolution: pc_src_o = mem_valid_o & branch_q & zero_q & ~br_fired. This is combinational from registers, so it asserts in the first cycle the branch is resident: latency 1 cycle from EX capture.
- br_fired is set on any edge where pc_src_o=1 and stall_i=1, so a stalled branch redirects exactly once.
- Redirect and flush: pc_src_o does not itself flush this register. The hazard unit flushes IF/ID and ID/EX.
- Timing: no combinational path from any input to any output.

Optional Feature:
- Macro: EXMEM_PERF_CNT_EN.
- With the macro defined, two extra outputs are added:
  - stall_cnt_o (32): increments on each edge with stall_i=1 and flush_i=0.
  - bubble_cnt_o (32): increments on each load edge with ex_valid_i=0, and on each flush edge.
- Both counters wrap at 2^32 to 0 and reset to 0.
- Without the macro: the ports, counters and logic are absent; the rest of the behaviour is identical.

Test Plan:
- Reset/load: rst_n low then high; load alu_out=0x0000_1000, rd=5, reg_write=1, valid=1 -> next cycle mem_alu_out_o=0x1000, mem_rd_o=5, mem_reg_write_o=1, mem_valid_o=1, pc_src_o=0.
- Branch taken: branch=1, zero=1, target=0x0000_0040, valid=1 -> pc_src_o=1 for exactly one cycle, br_target_o=0x40. Repeat with zero=0 -> pc_src_o stays 0.
- Stalled branch: branch=1, zero=1 captured, stall_i held 3 cycles -> pc_src_o high only in the first cycle, outputs frozen for 3 cycles.
- Flush vs stall: entry with mem_write=1 resident; assert flush_i=1 and stall_i=1 together -> next cycle mem_valid_o=0 and all control outputs 0.
- x0 and bubble: load rd=0, reg_write=1 -> mem_reg_write_o=0. Load ex_valid_i=0, mem_write=1 -> mem_mem_write_o=0, mem_valid_o=0.
- Async reset mid-operation: pull rst_n low between clock edges with a valid store resident -> outputs 0 immediately, without waiting for a clock edge. With EXMEM_PERF_CNT_EN: 4 stall edges then 2 bubble loads -> stall_cnt_o=4, bubble_cnt_o=2.

Source files
------------

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with BEQ resolution and a one-shot fetch redirect.
// Optional EXMEM_PERF_CNT_EN adds stall and bubble event counters.
module ex_mem_reg #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic                  ex_valid_i,
    input  logic [XLEN-1:0]       ex_alu_out_i,
    input  logic                  ex_zero_i,
    input  logic [XLEN-1:0]       ex_rs2_data_i,
    input  logic [REG_ADDR_W-1:0] ex_rd_i,
    input  logic [XLEN-1:0]       ex_br_target_i,
    input  logic                  ex_reg_write_i,
    input  logic                  ex_mem_read_i,
    input  logic                  ex_mem_write_i,
    input  logic                  ex_mem_to_reg_i,
    input  logic                  ex_branch_i,
    output logic                  mem_valid_o,
    output logic [XLEN-1:0]       mem_alu_out_o,
    output logic [XLEN-1:0]       mem_wdata_o,
    output logic [REG_ADDR_W-1:0] mem_rd_o,
    output logic                  mem_reg_write_o,
    output logic                  mem_mem_read_o,
    output logic                  mem_mem_write_o,
    output logic                  mem_mem_to_reg_o,
`ifdef EXMEM_PERF_CNT_EN
    output logic [31:0]           stall_cnt_o,
    output logic [31:0]           bubble_cnt_o,
`endif
    output logic                  pc_src_o,
    output logic [XLEN-1:0]       br_target_o
);

    logic                  valid_q, valid_d;
    logic [XLEN-1:0]       alu_q, alu_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [XLEN-1:0]       tgt_q, tgt_d;
    logic                  zero_q, zero_d;
    logic                  regw_q, regw_d;
    logic                  mrd_q, mrd_d;
    logic                  mwr_q, mwr_d;
    logic                  m2r_q, m2r_d;
    logic                  br_q, br_d;
    logic                  fired_q, fired_d;
    logic                  ctl_en;

    assign ctl_en = ex_valid_i;

    always_comb begin
        valid_d = valid_q;
        alu_d   = alu_q;
        wdata_d = wdata_q;
        rd_d    = rd_q;
        tgt_d   = tgt_q;
        zero_d  = zero_q;
        regw_d  = regw_q;
        mrd_d   = mrd_q;
        mwr_d   = mwr_q;
        m2r_d   = m2r_q;
        br_d    = br_q;
        fired_d = fired_q;
        if (flush_i) begin
            valid_d = 1'b0;
            alu_d   = '0;
            wdata_d = '0;
            rd_d    = '0;
            tgt_d   = '0;
            zero_d  = 1'b0;
            regw_d  = 1'b0;
            mrd_d   = 1'b0;
            mwr_d   = 1'b0;
            m2r_d   = 1'b0;
            br_d    = 1'b0;
            fired_d = 1'b0;
        end else if (stall_i) begin
            // A stalled branch must redirect fetch only once.
            fired_d = fired_q | pc_src_o;
        end else begin
            valid_d = ex_valid_i;
            alu_d   = ex_alu_out_i;
            wdata_d = ex_rs2_data_i;
            rd_d    = ex_rd_i;
            tgt_d   = ex_br_target_i;
            zero_d  = ex_zero_i;
            regw_d  = ctl_en & ex_reg_write_i & (ex_rd_i != '0);
            mrd_d   = ctl_en & ex_mem_read_i;
            mwr_d   = ctl_en & ex_mem_write_i;
            m2r_d   = ctl_en & ex_mem_to_reg_i;
            br_d    = ctl_en & ex_branch_i;
            fired_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            alu_q   <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            tgt_q   <= '0;
            zero_q  <= 1'b0;
            regw_q  <= 1'b0;
            mrd_q   <= 1'b0;
            mwr_q   <= 1'b0;
            m2r_q   <= 1'b0;
            br_q    <= 1'b0;
            fired_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            alu_q   <= alu_d;
            wdata_q <= wdata_d;
            rd_q    <= rd_d;
            tgt_q   <= tgt_d;
            zero_q  <= zero_d;
            regw_q  <= regw_d;
            mrd_q   <= mrd_d;
            mwr_q   <= mwr_d;
            m2r_q   <= m2r_d;
            br_q    <= br_d;
            fired_q <= fired_d;
        end
    end

    assign mem_valid_o      = valid_q;
    assign mem_alu_out_o    = alu_q;
    assign mem_wdata_o      = wdata_q;
    assign mem_rd_o         = rd_q;
    assign mem_reg_write_o  = regw_q;
    assign mem_mem_read_o   = mrd_q;
    assign mem_mem_write_o  = mwr_q;
    assign mem_mem_to_reg_o = m2r_q;
    assign br_target_o      = tgt_q;
    assign pc_src_o         = valid_q & br_q & zero_q & ~fired_q;

`ifdef EXMEM_PERF_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;
    logic [31:0] bubble_cnt_q, bubble_cnt_d;

    always_comb begin
        stall_cnt_d  = stall_cnt_q;
        bubble_cnt_d = bubble_cnt_q;
        if (stall_i && !flush_i) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
        if (flush_i || (!stall_i && !ex_valid_i)) begin
            bubble_cnt_d = bubble_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q  <= '0;
            bubble_cnt_q <= '0;
        end else begin
            stall_cnt_q  <= stall_cnt_d;
            bubble_cnt_q <= bubble_cnt_d;
        end
    end

    assign stall_cnt_o  = stall_cnt_q;
    assign bubble_cnt_o = bubble_cnt_q;
`endif

endmodule
